// File: rtl/hist_bin_locator.sv
// hist_bin_locator: signed sample -> histogram bin index with underflow/overflow status counters
// Optional feature: define HIST_BIN_LOCATOR_EDGE_FOLD_EN to emit out-of-range samples folded into the edge bins.
module hist_bin_locator #(
    parameter int DATA_W      = 16,
    parameter int BIN_INDEX_W = 6,
    parameter int N_BINS      = 64,
    parameter int CNT_W       = 32
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [DATA_W-1:0]              i_left_bound,
    input  logic [$clog2(DATA_W+1)-1:0]    i_width_log2,
    input  logic                           i_clear_cnt,
    input  logic [DATA_W-1:0]              asi_data,
    input  logic                           asi_valid,
    output logic                           asi_ready,
    output logic [BIN_INDEX_W-1:0]         aso_bin,
    output logic                           aso_valid,
    input  logic                           aso_ready,
    output logic [CNT_W-1:0]               o_underflow_cnt,
    output logic [CNT_W-1:0]               o_overflow_cnt
);
    localparam int WL_W = $clog2(DATA_W+1);
`ifdef HIST_BIN_LOCATOR_EDGE_FOLD_EN
    localparam bit FOLD = 1'b1;
`else
    localparam bit FOLD = 1'b0;
`endif
    logic                     adv;
    logic                     s1_valid;
    logic signed [DATA_W:0]   s1_diff;
    logic [WL_W-1:0]          s1_wl;
    logic signed [DATA_W:0]   q;
    logic                     under;
    logic                     over;
    logic                     emit;
    logic                     count;
    logic [BIN_INDEX_W-1:0]   bin;
    assign adv       = ~aso_valid | aso_ready;
    assign asi_ready = adv;
    assign count     = adv & s1_valid;
    // classify the stage-1 difference and pick the outgoing bin index
    always_comb begin
        q     = s1_diff >>> s1_wl;
        under = s1_diff[DATA_W];
        over  = !under && (int'(q) >= N_BINS);
        emit  = s1_valid && (FOLD || !(under || over));
        bin   = under ? '0 : over ? BIN_INDEX_W'(N_BINS-1) : q[BIN_INDEX_W-1:0];
    end
    // stage 1: exact one-bit-wider difference, config captured with the sample
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_diff  <= '0;
            s1_wl    <= '0;
        end else if (adv) begin
            s1_valid <= asi_valid;
            s1_diff  <= {asi_data[DATA_W-1], asi_data} - {i_left_bound[DATA_W-1], i_left_bound};
            s1_wl    <= i_width_log2;
        end
    end
    // stage 2: registered output, held while downstream stalls
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            aso_valid <= 1'b0;
            aso_bin   <= '0;
        end else if (adv) begin
            aso_valid <= emit;
            if (emit) aso_bin <= bin;
        end
    end
    // saturating underflow counter, clear beats increment
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear_cnt) o_underflow_cnt <= '0;
        else if (count && under && ~&o_underflow_cnt) o_underflow_cnt <= o_underflow_cnt + 1'b1;
    end
    // saturating overflow counter, clear beats increment
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear_cnt) o_overflow_cnt <= '0;
        else if (count && over && ~&o_overflow_cnt) o_overflow_cnt <= o_overflow_cnt + 1'b1;
    end
endmodule

// File: tb/tb_hist_bin_locator.sv
// tb_hist_bin_locator: scoreboard bench for hist_bin_locator (CNT_W=4 to reach saturation quickly)
module tb_hist_bin_locator;
`ifdef HIST_BIN_LOCATOR_EDGE_FOLD_EN
    localparam bit FOLD = 1'b1;
`else
    localparam bit FOLD = 1'b0;
`endif
    localparam int NB = 64;
    localparam int CMAX = 15;
    typedef struct {int bin; int cyc; bit lat;} exp_t;
    logic        clk = 0;
    logic        rst = 1;
    logic [15:0] i_left_bound = 0;
    logic [4:0]  i_width_log2 = 0;
    logic        i_clear_cnt = 0;
    logic [15:0] asi_data = 0;
    logic        asi_valid = 0;
    logic        asi_ready;
    logic [5:0]  aso_bin;
    logic        aso_valid;
    logic        aso_ready = 1;
    logic [3:0]  o_underflow_cnt;
    logic [3:0]  o_overflow_cnt;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lb = 0;
    int wl = 0;
    int exp_under = 0;
    int exp_over = 0;
    bit lat_en = 1;
    exp_t exp_q[$];
    bit hold_p = 0;
    logic [5:0] hold_bin = 0;

    hist_bin_locator #(.DATA_W(16), .BIN_INDEX_W(6), .N_BINS(NB), .CNT_W(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_left_bound(i_left_bound), .i_width_log2(i_width_log2),
        .i_clear_cnt(i_clear_cnt), .asi_data(asi_data), .asi_valid(asi_valid), .asi_ready(asi_ready),
        .aso_bin(aso_bin), .aso_valid(aso_valid), .aso_ready(aso_ready),
        .o_underflow_cnt(o_underflow_cnt), .o_overflow_cnt(o_overflow_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic push(input int b);
        exp_t e;
        e.bin = b;
        e.cyc = cyc;
        e.lat = lat_en;
        exp_q.push_back(e);
    endtask

    task automatic model(input int d);
        int diff, qq;
        diff = d - lb;
        if (diff < 0) begin
            exp_under = (exp_under == CMAX) ? CMAX : exp_under + 1;
            if (FOLD) push(0);
        end else begin
            qq = diff / (1 << wl);
            if (qq >= NB) begin
                exp_over = (exp_over == CMAX) ? CMAX : exp_over + 1;
                if (FOLD) push(NB - 1);
            end else push(qq);
        end
    endtask

    task automatic cfg(input int l, input int w);
        lb = l;
        wl = w;
        i_left_bound = 16'(l);
        i_width_log2 = 5'(w);
    endtask

    task automatic send(input int d);
        asi_data = 16'(d);
        asi_valid = 1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (asi_ready) break;
        end
        if (!asi_ready) check("send_timeout", 32'(asi_ready), 1);
        model(d);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        asi_valid = 0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag);
        check({tag, "_under"}, 32'(o_underflow_cnt), exp_under);
        check({tag, "_over"}, 32'(o_overflow_cnt), exp_over);
    endtask

    always @(negedge clk) begin
        if (!rst && aso_valid) begin
            if (hold_p) check("hold_bin", 32'(aso_bin), 32'(hold_bin));
            if (!aso_ready) check("rdy_stall", 32'(asi_ready), 0);
            else if (exp_q.size() == 0) check("unexpected_out", 32'(aso_bin), 999);
            else begin
                exp_t e;
                e = exp_q.pop_front();
                check("bin", 32'(aso_bin), e.bin);
                if (e.lat) check("latency", cyc - e.cyc, 2);
            end
        end
        hold_p = !rst && aso_valid && !aso_ready;
        hold_bin = aso_bin;
    end

    initial begin
        cfg(100, 2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(aso_valid), 0);
        check("rst_bin", 32'(aso_bin), 0);
        check("rst_ready", 32'(asi_ready), 1);
        check_cnt("rst");
        @(posedge clk);
        #1;
        rst = 0;
        foreach (exp_q[i]) ;
        send(100); send(103); send(104); send(355);
        idle(5);
        check_cnt("inrange");
        send(99); send(356); send(-32768);
        idle(5);
        check_cnt("oor");
        lat_en = 0;
        fork
            begin
                for (int i = 0; i < 10; i++) send(100 + 4 * i);
                idle(1);
            end
            begin
                repeat (3) @(posedge clk);
                #1 aso_ready = 0;
                repeat (4) @(posedge clk);
                #1 aso_ready = 1;
            end
        join
        idle(8);
        lat_en = 1;
        cfg(32767, 0);
        send(-32768);
        cfg(-32768, 0);
        send(32767);
        cfg(-32768, 2);
        send(-32768 + 255);
        send(-32768 + 256);
        idle(5);
        check_cnt("extreme");
        cfg(-100, 0);
        send(-100); send(-36); send(-37);
        cfg(-100, 4);
        idle(5);
        check_cnt("wl_change");
        i_clear_cnt = 1;
        @(posedge clk);
        #1 i_clear_cnt = 0;
        exp_under = 0;
        exp_over = 0;
        check_cnt("clear");
        cfg(100, 2);
        for (int i = 0; i < 17; i++) send(99);
        idle(5);
        check_cnt("saturate");
        send(99);
        asi_valid = 0;
        i_clear_cnt = 1;
        @(posedge clk);
        #1 i_clear_cnt = 0;
        exp_under = 0;
        exp_over = 0;
        idle(3);
        check_cnt("clear_vs_inc");
        aso_ready = 0;
        send(100); send(104);
        rst = 1;
        asi_valid = 0;
        @(posedge clk);
        #1;
        exp_q.delete();
        exp_under = 0;
        exp_over = 0;
        check("midrst_valid", 32'(aso_valid), 0);
        check("midrst_ready", 32'(asi_ready), 1);
        check_cnt("midrst");
        rst = 0;
        aso_ready = 1;
        idle(6);
        check_cnt("post_rst");
        check("drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/hist_bin_locator.md
# hist_bin_locator

Upstream stage of the histogram bin-increment path. Accepts a stream of signed samples, subtracts a programmable left bound, divides by a power-of-two bin width, and emits the resulting binary bin index on a valid/ready stream that feeds the binary-to-onehot bin-select decoder. Out-of-range samples are classified as underflow or overflow and counted in two saturating status counters.

## Interface
- DATA_W, 16, sample width (signed two's complement)
- BIN_INDEX_W, 6, output bin index width
- N_BINS, 64, number of valid bins; must satisfy N_BINS <= 2^BIN_INDEX_W
- CNT_W, 32, status counter width

- i_clk  in  1  single clock
- i_rst  in  1  synchronous, active-high reset
- i_left_bound  in  DATA_W  signed lower edge of bin 0
- i_width_log2  in  $clog2(DATA_W+1)  bin width = 2^i_width_log2; legal 0..DATA_W
- i_clear_cnt  in  1  single-cycle clear of both status counters
- asi_data  in  DATA_W  input sample
- asi_valid  in  1  sample valid
- asi_ready  out  1  sink ready
- aso_bin  out  BIN_INDEX_W  bin index to onehot decoder
- aso_valid  out  1  bin index valid
- aso_ready  in  1  downstream ready
- o_underflow_cnt  out  CNT_W  samples below i_left_bound
- o_overflow_cnt  out  CNT_W  samples at or above i_left_bound + N_BINS*2^i_width_log2

## Operation
- Two-stage stall-all pipeline; advance enable adv = ~aso_valid | aso_ready; asi_ready = adv (registered-free, combinational from aso_valid/aso_ready).
- Transfer on asi_valid & asi_ready; transfer out on aso_valid & aso_ready.
- Stage 1 (on adv): diff = sext(asi_data) - sext(i_left_bound), DATA_W+1 bits signed; register diff, i_width_log2, valid. Config is captured per sample; later config changes do not affect samples already in flight.
- Stage 2 (on adv): q = diff >>> width_log2 (arithmetic, full DATA_W+1 bits). Class: underflow if diff < 0; overflow if q >= N_BINS; else in-range.
- In-range: aso_bin = q[BIN_INDEX_W-1:0], aso_valid = 1.
- Underflow/overflow: sample consumed, aso_valid stays 0 for that slot, corresponding counter increments by 1 in the cycle stage 2 loads the sample.
- Counters saturate at 2^CNT_W-1. i_clear_cnt has priority over a same-cycle increment (result 0).
- Stage 2 with aso_valid=1 and aso_ready=0 holds aso_bin stable; no stage loads.

## Timing
- Latency: 2 cycles from input transfer to aso_valid, with no backpressure.
- Throughput: 1 sample/cycle when aso_ready held high.
- Counters update the cycle after stage 1 holds the sample (same edge aso_valid would rise).
- Reset values: aso_valid 0, aso_bin 0, o_underflow_cnt 0, o_overflow_cnt 0, both stage valids 0. asi_ready is 1 during and after reset (follows aso_valid = 0).
- Reset mid-operation: in-flight samples discarded, not counted, never emitted.
- Boundary: diff = 0 → bin 0; diff = N_BINS*2^w - 1 → bin N_BINS-1; diff = N_BINS*2^w → overflow. Extreme inputs (asi_data = -2^(DATA_W-1), i_left_bound = 2^(DATA_W-1)-1) must not wrap: DATA_W+1-bit diff is exact.

## Configuration
- Macro HIST_BIN_LOCATOR_EDGE_FOLD_EN.
- Defined: out-of-range samples are emitted instead of dropped; underflow → aso_bin = 0, overflow → aso_bin = N_BINS-1, aso_valid = 1. Counters still increment exactly as without the macro.
- Undefined: out-of-range samples are dropped as described in Operation.

## Test plan
- DATA_W=16, N_BINS=64, i_left_bound=100, i_width_log2=2; samples 100, 103, 104, 355 → aso_bin 0, 0, 1, 63 two cycles after each transfer; counters stay 0.
- Same config; samples 99, 356, -32768 → no aso_valid; o_underflow_cnt=2, o_overflow_cnt=1 (with EDGE_FOLD_EN: aso_bin 0, 63, 0 emitted, same counts).
- Stream 10 back-to-back samples, aso_ready low for cycles 3-6 → asi_ready low same cycles, aso_bin held, all 10 indices emitted in order, none lost or duplicated.
- i_left_bound=-100, i_width_log2=0; sample -100 → bin 0, -37 → bin 63, -36 → overflow; change i_width_log2 to 4 while -37 in stage 1 → still bin 63.
- Preload counters to 2^CNT_W-1 via forced underflows (CNT_W=4) → holds at 15; assert i_clear_cnt same cycle as an underflow increment → counter reads 0.
- Assert i_rst with two samples in flight → aso_valid 0 next cycle, counters 0, those samples never appear.
